// File: rtl/seq_cla_pkg.sv
// Shared definitions for the multi-cycle carry-lookahead adder/subtractor.
package seq_cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int slice_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/seq_cla_adder_slice.sv
// Combinational 4-bit carry-lookahead slice; the top reuses it once per clock.
module cla_slice
  import seq_cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               g,
  output logic               p,
  output logic               c3,
  output logic               cout
);

  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign g    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign p    = &w_p;
  assign cout = g | (p & cin);
  assign c3   = w_c[3];
  assign s    = w_p ^ w_c;

endmodule

// File: rtl/seq_cla_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one 4-bit CLA slice per clock,
// inter-slice carry held in a register, start/busy/done handshake.
module seq_cla_adder
  import seq_cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             overflow
);

  localparam int N  = slice_count(WIDTH);
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_t             r_state;
  logic [KW-1:0]      r_k;
  logic               r_carry;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH:0]     r_sum;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;

  logic               w_fast;
  logic               w_step;
  logic [KW-1:0]      w_idx;
  logic               w_last;
  logic [SLICE_W-1:0] w_sa;
  logic [SLICE_W-1:0] w_sb;
  logic               w_sc;
  logic [SLICE_W-1:0] w_s;
  logic               w_g;
  logic               w_p;
  logic               w_c3;
  logic               w_cout;
  logic               w_next_c;

  // A start accepted in DONE computes slice 0 straight from the inputs in that
  // same cycle, so back-to-back results arrive every N cycles.
  assign w_fast = (r_state == DONE) && start;
  assign w_step = (r_state == RUN) || w_fast;
  assign w_idx  = w_fast ? '0 : r_k;
  assign w_last = (w_idx == KW'(N - 1));

  assign w_sa = w_fast ? a[SLICE_W-1:0] : r_opa[{w_idx, 2'b00} +: SLICE_W];
  assign w_sb = w_fast ? (sub ? ~b[SLICE_W-1:0] : b[SLICE_W-1:0])
                       : r_opb[{w_idx, 2'b00} +: SLICE_W];
  assign w_sc = w_fast ? (cin ^ sub) : r_carry;

  cla_slice u_slice (
    .a    (w_sa),
    .b    (w_sb),
    .cin  (w_sc),
    .s    (w_s),
    .g    (w_g),
    .p    (w_p),
    .c3   (w_c3),
    .cout (w_cout)
  );

  assign w_next_c = w_g | (w_p & w_sc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_step) begin
        r_sum[{w_idx, 2'b00} +: SLICE_W] <= w_s;
        r_carry <= w_next_c;
        r_k     <= w_idx + 1'b1;
        if (w_fast) begin
          r_opa <= a;
          r_opb <= sub ? ~b : b;
        end
        if (w_last) begin
          r_sum[WIDTH] <= w_cout;
          r_ovf        <= w_c3 ^ w_cout;
          r_state      <= DONE;
          r_busy       <= 1'b0;
          r_done       <= 1'b1;
        end else begin
          r_state <= RUN;
          r_busy  <= 1'b1;
        end
      end else if (start) begin
        r_opa   <= a;
        r_opb   <= sub ? ~b : b;
        r_carry <= cin ^ sub;
        r_k     <= '0;
        r_state <= RUN;
        r_busy  <= 1'b1;
      end else begin
        r_state <= IDLE;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_seq_cla_adder.sv
// Bench for seq_cla_adder (WIDTH=16): directed and random operations checked
// against an integer-arithmetic reference model.
module tb_seq_cla_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W:0]   sum;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_cla_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .overflow (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mc, input logic ms,
                                output logic [W:0] es, output logic eo);
    int sa, sb, r, ud;
    sa = $signed(ma);
    sb = $signed(mb);
    if (!ms) begin
      ud = int'(ma) + int'(mb) + int'(mc);
      es = ud[W:0];
      r  = sa + sb + int'(mc);
    end else begin
      ud = int'(ma) - int'(mb) - int'(mc);
      es = {(ud >= 0), ud[W-1:0]};
      r  = sa - sb - int'(mc);
    end
    eo = (r > 32767) || (r < -32768);
  endfunction

  task automatic randomize_inputs();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, input string tag);
    logic [W:0] es;
    logic       eo;
    int         cyc, bc;
    model(ta, tb_, tc, ts, es, eo);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    randomize_inputs();
    cyc = 0;
    bc  = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy) bc++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, 4);
    chk({tag, " busy_cycles"}, bc, 4);
    chk({tag, " sum"}, 32'(sum), 32'(es));
    chk({tag, " overflow"}, 32'(overflow), 32'(eo));
    chk({tag, " busy_at_done"}, 32'(busy), 0);
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    logic [W:0] es1, es2;
    logic       eo1, eo2;
    int         dcount, first, t1, t2, extra;

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset sum", 32'(sum), 0);
    chk("reset overflow", 32'(overflow), 0);

    // Reset has priority over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 16'h0101; b = 16'h0202;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_over_start busy", 32'(busy), 0);

    run_op(16'h0006, 16'h000C, 1'b1, 1'b0, "add_small");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "add_max");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
    run_op(16'h000D, 16'h0003, 1'b0, 1'b1, "sub_pos");
    run_op(16'h0003, 16'h000D, 1'b0, 1'b1, "sub_neg");
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
    run_op(16'h0000, 16'h0000, 1'b1, 1'b1, "sub_borrow");

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "random");
    end

    // A second start during RUN must be ignored.
    model(16'h1357, 16'h2468, 1'b0, 1'b0, es1, eo1);
    @(negedge clk);
    a = 16'h1357; b = 16'h2468; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dcount = 0;
    first  = -1;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        dcount++;
        if (first < 0) begin
          first = i;
          chk("ignore sum", 32'(sum), 32'(es1));
          chk("ignore overflow", 32'(overflow), 32'(eo1));
        end
      end
      if (i == 1) begin
        start = 1'b1; a = 16'hFFFF; b = 16'hAAAA; sub = 1'b1; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("ignore latency", first, 4);
    chk("ignore done_count", dcount, 1);

    // Back-to-back with start held through DONE.
    model(16'hA5A5, 16'h1111, 1'b1, 1'b0, es1, eo1);
    model(16'h4000, 16'hC000, 1'b0, 1'b1, es2, eo2);
    @(negedge clk);
    a = 16'hA5A5; b = 16'h1111; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    t1 = -1;
    t2 = -1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        if (t1 < 0) begin
          t1 = i;
          chk("b2b first sum", 32'(sum), 32'(es1));
          chk("b2b first overflow", 32'(overflow), 32'(eo1));
          a = 16'h4000; b = 16'hC000; cin = 1'b0; sub = 1'b1;
        end else if (t2 < 0) begin
          t2 = i;
          chk("b2b second sum", 32'(sum), 32'(es2));
          chk("b2b second overflow", 32'(overflow), 32'(eo2));
        end
      end
      if (t1 >= 0 && i == t1 + 1) begin
        start = 1'b0;
        randomize_inputs();
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b first latency", t1, 4);
    chk("b2b spacing", t2 - t1, 4);

    // Reset in the second RUN cycle aborts the operation.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort sum", 32'(sum), 0);
    chk("abort overflow", 32'(overflow), 0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) extra++;
      @(negedge clk);
    end
    chk("abort no_done", extra, 0);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, "after_abort");
    chk("after_abort literal", 32'(sum), 32'h05555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_cla_adder.md
# seq_cla_adder

Multi-cycle, parametrised carry-lookahead adder/subtractor. It processes WIDTH-bit operands one 4-bit CLA slice per clock and keeps the inter-slice carry in a register. It uses a start/busy/done handshake and latches its result. It is the wide-operand successor to the team's 4-bit combinational CLA, sized for datapaths where one slice of hardware is reused instead of replicated.

## Interface
Parameters:
- WIDTH, 16: operand width in bits. Must be a multiple of 4 and ≥ 4. Slice count N = WIDTH/4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation. Sampled only in IDLE or DONE.
- sub  in  1  0 = add, 1 = subtract. Latched with the operands on start.
- a  in  WIDTH  operand A. Latched on start.
- b  in  WIDTH  operand B. Latched on start.
- cin  in  1  carry-in for add, borrow-in for subtract. Latched on start.
- busy  out  1  high while slices are being processed.
- done  out  1  one-cycle pulse: result valid.
- sum  out  WIDTH+1  result. sum[WIDTH] is carry-out; for subtract it is the inverted borrow (1 = no borrow).
- overflow  out  1  two's-complement signed overflow of the WIDTH-bit result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1:
  - Latch opA = a, opB = sub ? ~b : b, carry = sub ? ~cin : cin.
  - Clear slice index k = 0; go to RUN.
- RUN, each cycle:
  - Feed cla_slice with opA[4k+3:4k], opB[4k+3:4k] and carry.
  - Write the slice sum into the result register bits [4k+3:4k], the slice carry-out into carry, and increment k.
  - After slice N-1: write sum[WIDTH] = carry-out, compute overflow = carry into MSB XOR carry out of MSB, go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 here is accepted (back-to-back, same as IDLE).
  - Otherwise go to IDLE.
- sum/overflow hold their last value in IDLE.
- They are not cleared on a new start until overwritten slice by slice. The bench must only sample them while done=1.
- start while in RUN is ignored: no latch, no restart, busy stays high.
- Arithmetic:
  - add: sum = a + b + cin, modulo 2^(WIDTH+1).
  - sub: sum[WIDTH-1:0] = a − b − cin, modulo 2^WIDTH.
- Operand inputs may change freely after the start cycle.

## Timing
- Reset values:
  - state = IDLE, k = 0, carry = 0.
  - busy = 0, done = 0, sum = 0, overflow = 0.
- Reset wins over start in the same cycle.
- Reset mid-RUN aborts the operation: outputs reach reset values after that edge and no done pulse follows.
- start sampled at edge E0:
  - busy = 1 after E0 through E0+N−1.
  - DONE state and done = 1 after edge E0+N. Latency is N cycles; 4 for WIDTH = 16.
- busy and done are never high together.
- Throughput: one result per N+1 cycles. With start held high in DONE, one result per N cycles.
- No combinational path from inputs to outputs. All outputs are registered.

## Structure
- Shared package seq_cla_pkg holds:
  - SLICE_W = 4.
  - state enum {IDLE, RUN, DONE}.
  - A function returning N from WIDTH.
- Sub-module cla_slice: combinational 4-bit CLA with inputs a[3:0], b[3:0], cin and outputs s[3:0], g/p group signals, c3 (carry into bit 3, for overflow) and cout.
- Top level: FSM, slice counter, operand/result registers and the mux selecting the active slice.

## Test plan
All scenarios use WIDTH = 16.
- Add 0x0006 + 0x000C, cin = 1 -> done 4 cycles after start; sum = 0x00013, overflow = 0; busy high for exactly 4 cycles.
- Add 0xFFFF + 0xFFFF, cin = 1 -> sum = 0x1FFFF, overflow = 0. Add 0x7FFF + 0x0001, cin = 0 -> sum = 0x08000, overflow = 1.
- Subtract 0x000D − 0x0003, cin = 0 -> sum = 0x1000A. Subtract 0x0003 − 0x000D -> sum = 0x0FFF6. Subtract 0x8000 − 0x0001 -> overflow = 1.
- start pulsed again during RUN with different operands -> ignored. The first result appears unchanged at the expected cycle and only one done pulse occurs.
- Back-to-back: start held high through DONE -> second operation accepted in the DONE cycle, second done exactly 4 cycles after the first.
- rst asserted in the 2nd RUN cycle -> next cycle busy = 0, done = 0, sum = 0, overflow = 0, no done pulse. A subsequent start of 0x1234 + 0x4321 -> sum = 0x05555.
